// File: rtl/realtime_channel_arbiter_if.sv
// Realtime_Parallel_If: parallel realtime bus. Each lane carries one sample
// plus a valid bit. There is no ready, so the receiver can never stall the source.
//   data  [CHANNELS][DWIDTH] : per-lane sample
//   valid [CHANNELS]         : per-lane sample strobe
interface Realtime_Parallel_If #(
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned CHANNELS = 8
);
  logic [CHANNELS-1:0][DWIDTH-1:0] data;
  logic [CHANNELS-1:0]             valid;

  modport Master (output data, output valid);
  modport Slave  (input  data, input  valid);
endinterface

// File: rtl/realtime_channel_arbiter.sv
// realtime_channel_arbiter: merges CHANNELS no-backpressure sample streams onto
// one stream. Each channel has a small FIFO. A round-robin scheduler drains at
// most one sample per cycle. Overruns are dropped and flagged in sticky
// per-channel bits.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   enable          : run control; low flushes FIFOs and idles the output
//   data_in         : CHANNELS-wide parallel input stream (no ready)
//   data_out        : single-lane merged output stream (registered)
//   channel_out     : source channel of the current data_out sample
//   clear_overflow  : per-channel clear strobes for overflow
//   overflow        : sticky per-channel drop flags (set wins over clear)
module realtime_channel_arbiter #(
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned CHANNELS   = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  Realtime_Parallel_If.Slave          data_in,
  Realtime_Parallel_If.Master         data_out,
  output logic [$clog2(CHANNELS)-1:0] channel_out,
  input  logic [CHANNELS-1:0]         clear_overflow,
  output logic [CHANNELS-1:0]         overflow
);

  localparam int unsigned CH_W   = $clog2(CHANNELS);
  localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  // FIFO storage and bookkeeping
  logic [CHANNELS-1:0][FIFO_DEPTH-1:0][DWIDTH-1:0] mem_q, mem_d;
  logic [CHANNELS-1:0][ADDR_W-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [CHANNELS-1:0][ADDR_W-1:0]                 rd_ptr_q, rd_ptr_d;
  logic [CHANNELS-1:0][CNT_W-1:0]                  count_q, count_d;

  // Scheduler and output registers
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                out_valid_q, out_valid_d;
  logic [DWIDTH-1:0]   out_data_q, out_data_d;
  logic [CH_W-1:0]     channel_q, channel_d;
  logic [CHANNELS-1:0] overflow_q, overflow_d;

  // Combinational helpers
  logic                grant_valid;
  logic [CH_W-1:0]     grant_idx;
  logic [CH_W:0]       cand;
  logic [CHANNELS-1:0] full;
  logic [CHANNELS-1:0] push;
  logic [CHANNELS-1:0] pop;
  logic [CHANNELS-1:0] drop;
  logic [DWIDTH-1:0]   head_data;

  // Round-robin grant over last edge's occupancy. The loop runs backwards so
  // the candidate closest to the pointer overwrites all later ones.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + (CH_W+1)'(k);
      if (cand >= (CH_W+1)'(CHANNELS)) begin
        cand = cand - (CH_W+1)'(CHANNELS);
      end
      if (count_q[cand[CH_W-1:0]] != '0) begin
        grant_valid = 1'b1;
        grant_idx   = cand[CH_W-1:0];
      end
    end
    // A disabled block never issues a grant, so valid drops at the next edge.
    if (!enable) begin
      grant_valid = 1'b0;
    end
  end

  // Per-channel push/pop/drop decisions. A full FIFO still accepts a sample
  // when it is popped in the same cycle.
  always_comb begin
    full = '0;
    push = '0;
    pop  = '0;
    drop = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      full[i] = (count_q[i] == CNT_W'(FIFO_DEPTH));
      pop[i]  = grant_valid && (grant_idx == CH_W'(i));
      push[i] = enable && data_in.valid[i] && (!full[i] || pop[i]);
      drop[i] = enable && data_in.valid[i] && full[i] && !pop[i];
    end
  end

  assign head_data = mem_q[grant_idx][rd_ptr_q[grant_idx]];

  // FIFO next state; disable flushes every FIFO at once.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = data_in.data[i];
        wr_ptr_d[i]           = wr_ptr_q[i] + ADDR_W'(1);
      end
      if (pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + ADDR_W'(1);
      end
      case ({push[i], pop[i]})
        2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
        2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
        default: count_d[i] = count_q[i];
      endcase
    end
    if (!enable) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Output register, pointer advance and sticky overflow (set beats clear).
  always_comb begin
    out_valid_d = grant_valid;
    out_data_d  = out_data_q;
    channel_d   = channel_q;
    rr_ptr_d    = rr_ptr_q;
    overflow_d  = (overflow_q & ~clear_overflow) | drop;
    if (grant_valid) begin
      out_data_d = head_data;
      channel_d  = grant_idx;
      rr_ptr_d   = (grant_idx == CH_W'(CHANNELS - 1)) ? '0 : grant_idx + CH_W'(1);
    end
    if (!enable) begin
      rr_ptr_d = '0;
    end
  end

  // Control and output state
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      channel_q   <= '0;
      overflow_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      channel_q   <= channel_d;
      overflow_q  <= overflow_d;
    end
  end

  // Sample storage needs no reset; occupancy counters gate all reads.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign data_out.data[0]  = out_data_q;
  assign data_out.valid[0] = out_valid_q;
  assign channel_out       = channel_q;
  assign overflow          = overflow_q;

endmodule

// File: doc/realtime_channel_arbiter.md
# realtime_channel_arbiter

Merges the CHANNELS independent no-backpressure sample streams of a parallel realtime bus onto a single realtime output. Each sample is tagged with the index of its source channel. Every input channel has a small FIFO, and a round-robin scheduler drains one sample per cycle. Because the inputs cannot be stalled, FIFO overruns are dropped and reported through sticky per-channel flags. The block sits between the multi-channel ADC/processing stages and single-stream consumers such as the DMA packer.

## Interface
- DWIDTH, 32: sample width in bits.
- CHANNELS, 8: number of input channels (≥2).
- FIFO_DEPTH, 4: per-channel FIFO depth in samples (power of 2, ≥2).
- clk  input  1  single clock for all logic.
- reset  input  1  synchronous, active-high.
- enable  input  1  run control; 0 = flush and idle.
- data_in  Realtime_Parallel_If.Slave  DWIDTH×CHANNELS  parallel input streams; data and valid per channel; no ready.
- data_out  Realtime_Parallel_If.Master  DWIDTH×1  merged output stream, CHANNELS=1.
- channel_out  output  $clog2(CHANNELS)  source channel of the current data_out sample; valid only when data_out.valid=1.
- clear_overflow  input  CHANNELS  per-channel clear strobe for the overflow flags.
- overflow  output  CHANNELS  sticky per-channel flag; bit i=1 means channel i dropped at least one sample.

## Operation
- Reset values: data_out.valid=0, data_out.data=0, channel_out=0, overflow=0, all FIFOs empty, RR pointer=0.
- Write side, evaluated per channel i on each clock edge with enable=1:
  - if data_in.valid[i]=1 and FIFO i is not full, or is full but is being read in the same cycle, the sample is pushed;
  - otherwise the sample is dropped and overflow[i] is set.
- Scheduler: each cycle it examines the occupancy registered at the previous edge.
  - It grants the first non-empty channel at or after the RR pointer, wrapping modulo CHANNELS.
  - After a grant, the pointer moves to grant+1, wrapping to 0 after CHANNELS-1.
  - If no FIFO is occupied there is no grant and the pointer holds.
- Output register: on a grant, the FIFO head is popped into data_out.data and the channel index into channel_out, with valid=1. With no grant, valid=0 and data/channel_out hold their last values.
- At most one sample is output per cycle. Sustained aggregate input above 1 sample/cycle therefore overflows by design.
- Overflow flags: clear_overflow[i] clears bit i. If set and clear for bit i occur in the same cycle, set wins.
- Setting enable=0:
  - all FIFOs are flushed;
  - the pointer resets to 0;
  - inputs are ignored and overflow is not set;
  - data_out.valid=0 starting from the next edge;
  - overflow flags and clear_overflow keep operating normally.
- Re-enabling starts the block from the empty state.
- A reset mid-operation discards all buffered data and returns every output to its reset value on the next edge.

## Timing
- Latency: an input sample captured at edge t (pushed) can appear on data_out at edge t+1 at the earliest, as long as its FIFO was empty and no other channel was ahead in RR order. The output is registered, so the sample is visible during the cycle after edge t+1.
- Worst-case wait, with all FIFOs non-empty: CHANNELS-1 cycles beyond the minimum latency.
- Ordering: samples within a channel stay in FIFO order. Ordering across channels follows round-robin only.
- FIFO occupancy counter width: $clog2(FIFO_DEPTH)+1.
  - Push without pop: count+1.
  - Pop without push: count-1.
  - Push and pop together: unchanged.
- overflow is updated at the same edge as the dropped write attempt.

## Test plan
- Single channel: channel 2 sends 5 samples 0x10..0x14 on consecutive cycles with the others idle. Expect 5 outputs 0x10..0x14, channel_out=2, on consecutive cycles, first output one edge after the first push, overflow=0.
- Fairness burst: all 8 channels valid for one cycle with data 0xA0+i. Expect 8 consecutive outputs with channel_out 0,1,…,7 and matching data, then valid=0.
- Round-robin wrap: with the pointer at 6, push one sample each on channels 1 and 7. Expect channel 7 output first, then channel 1, and the pointer ends at 2.
- Overflow: all channels valid continuously for 20 cycles with FIFO_DEPTH=4. Expect overflow=0xFF.
  - Every output has a channel_out consistent with RR order.
  - Per-channel sequence numbers are monotonic, with gaps only where samples were dropped.
- Set/clear collision: overflow[3]=1, then assert clear_overflow[3] in the same cycle channel 3 drops again. Expect overflow[3] to stay 1. Clearing on a later idle cycle gives 0.
- Flush/reset: with FIFOs partly full, drop enable for 1 cycle, then pulse reset mid-stream on a later run. Expect in both cases no outputs from the pre-flush samples, data_out.valid=0 from the next edge, and pointer=0, so the first output after restart comes from the lowest-index active channel.
